// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C write master: FSM states, default
// prescaler divide and the frame width.
package i2c_pkg;

    localparam int I2C_CLK_DIV_DEF = 125;
    localparam int I2C_FRAME_W     = 24;

    typedef enum logic [2:0] {
        IDLE,
        START,
        BIT,
        ACKBIT,
        STOP
    } i2c_state_t;

endpackage

// File: rtl/i2c_tick_gen.sv
// Quarter-period prescaler: down-counter reloaded to CLK_DIV-1, emits a
// one-clk tick at terminal count while enabled. Held at reload value by clear.
module i2c_tick_gen
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = I2C_CLK_DIV_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tick
);

    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LOAD = CW'(CLK_DIV - 1);

    logic [CW-1:0] r_cnt;

    // Count down while enabled, reload on terminal count or clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= LOAD;
        end else if (i_clr) begin
            r_cnt <= LOAD;
        end else if (i_en) begin
            if (r_cnt == '0) begin
                r_cnt <= LOAD;
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    assign o_tick = i_en && !i_clr && (r_cnt == '0);

endmodule

// File: rtl/i2c_write_master.sv
// I2C write-only master: START, three bytes each followed by an ACK slot,
// STOP. Every phase is four prescaler quarters long. SCL and SDA enable are
// registered; SDA is open-drain (drives 0 or releases).
//
// state  | meaning
// IDLE   | SCL=1, SDA released; waits for start, done/ack hold result
// START  | q0-q1 SDA released, q2-q3 SDA low, SCL high throughout
// BIT    | one data bit: SCL low q0-q1, high q2-q3; SDA set at q0 entry
// ACKBIT | SDA released; slave level sampled at end of q2 (0 = ACK)
// STOP   | q0 SCL low/SDA low, q1 SCL high/SDA low, q2-q3 SDA released
module i2c_write_master
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = I2C_CLK_DIV_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [I2C_FRAME_W-1:0] i2c_data,
    input  logic                   start,
    output logic                   done,
    output logic                   ack,
    output logic                   i2c_sclk,
    inout  wire                    i2c_sdat
);

    i2c_state_t             r_state, w_state_nx;
    logic [1:0]             r_qtr, w_qtr_nx;
    logic [2:0]             r_bit, w_bit_nx;
    logic [1:0]             r_byte, w_byte_nx;
    logic [I2C_FRAME_W-1:0] r_shift, w_shift_nx;
    logic                   r_ack_acc, w_ack_acc_nx;
    logic                   r_done, w_done_nx;
    logic                   r_ack, w_ack_nx;
    logic                   r_scl, w_scl_nx;
    logic                   r_sda_oe, w_sda_oe_nx;

    logic w_presc_en;
    logic w_tick;

    assign w_presc_en = (r_state != IDLE);

    i2c_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk    (clk),
        .reset  (reset),
        .i_en   (w_presc_en),
        .i_clr  (!w_presc_en),
        .o_tick (w_tick)
    );

    // State and datapath registers; reset drops the bus immediately, no STOP
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_qtr     <= '0;
            r_bit     <= '0;
            r_byte    <= '0;
            r_shift   <= '0;
            r_ack_acc <= 1'b0;
            r_done    <= 1'b0;
            r_ack     <= 1'b0;
            r_scl     <= 1'b1;
            r_sda_oe  <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_qtr     <= w_qtr_nx;
            r_bit     <= w_bit_nx;
            r_byte    <= w_byte_nx;
            r_shift   <= w_shift_nx;
            r_ack_acc <= w_ack_acc_nx;
            r_done    <= w_done_nx;
            r_ack     <= w_ack_nx;
            r_scl     <= w_scl_nx;
            r_sda_oe  <= w_sda_oe_nx;
        end
    end

    // Next-state and next bus levels; bus levels change only on quarter ticks
    always_comb begin
        w_state_nx   = r_state;
        w_qtr_nx     = r_qtr;
        w_bit_nx     = r_bit;
        w_byte_nx    = r_byte;
        w_shift_nx   = r_shift;
        w_ack_acc_nx = r_ack_acc;
        w_done_nx    = r_done;
        w_ack_nx     = r_ack;
        w_scl_nx     = r_scl;
        w_sda_oe_nx  = r_sda_oe;

        if (w_tick) begin
            w_qtr_nx = r_qtr + 2'd1;
        end

        case (r_state)
            IDLE: begin
                w_scl_nx    = 1'b1;
                w_sda_oe_nx = 1'b0;
                if (start) begin
                    w_state_nx   = START;
                    w_shift_nx   = i2c_data;
                    w_done_nx    = 1'b0;
                    w_ack_nx     = 1'b0;
                    w_ack_acc_nx = 1'b1;
                    w_qtr_nx     = '0;
                    w_bit_nx     = '0;
                    w_byte_nx    = '0;
                end
            end
            START: begin
                if (w_tick) begin
                    if (r_qtr == 2'd1) begin
                        w_sda_oe_nx = 1'b1;
                    end
                    if (r_qtr == 2'd3) begin
                        w_state_nx  = BIT;
                        w_scl_nx    = 1'b0;
                        w_sda_oe_nx = !r_shift[I2C_FRAME_W-1];
                    end
                end
            end
            BIT: begin
                if (w_tick) begin
                    if (r_qtr == 2'd1) begin
                        w_scl_nx = 1'b1;
                    end
                    if (r_qtr == 2'd3) begin
                        w_scl_nx   = 1'b0;
                        w_shift_nx = {r_shift[I2C_FRAME_W-2:0], 1'b0};
                        if (r_bit == 3'd7) begin
                            w_state_nx  = ACKBIT;
                            w_bit_nx    = '0;
                            w_sda_oe_nx = 1'b0;
                        end else begin
                            w_bit_nx    = r_bit + 3'd1;
                            w_sda_oe_nx = !r_shift[I2C_FRAME_W-2];
                        end
                    end
                end
            end
            ACKBIT: begin
                if (w_tick) begin
                    if (r_qtr == 2'd1) begin
                        w_scl_nx = 1'b1;
                    end
                    if (r_qtr == 2'd2) begin
                        w_ack_acc_nx = r_ack_acc & !i2c_sdat;
                    end
                    if (r_qtr == 2'd3) begin
                        w_scl_nx = 1'b0;
                        if (r_byte == 2'd2) begin
                            w_state_nx  = STOP;
                            w_sda_oe_nx = 1'b1;
                        end else begin
                            w_state_nx  = BIT;
                            w_byte_nx   = r_byte + 2'd1;
                            w_sda_oe_nx = !r_shift[I2C_FRAME_W-1];
                        end
                    end
                end
            end
            STOP: begin
                if (w_tick) begin
                    if (r_qtr == 2'd0) begin
                        w_scl_nx = 1'b1;
                    end
                    if (r_qtr == 2'd1) begin
                        w_sda_oe_nx = 1'b0;
                    end
                    if (r_qtr == 2'd3) begin
                        w_state_nx = IDLE;
                        w_done_nx  = 1'b1;
                        w_ack_nx   = r_ack_acc;
                    end
                end
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
    end

    assign i2c_sclk = r_scl;
    assign i2c_sdat = r_sda_oe ? 1'b0 : 1'bz;
    assign done     = r_done;
    assign ack      = r_ack;

endmodule

// File: tb/tb_i2c_write_master.sv
// Bench for i2c_write_master with CLK_DIV=4: an SCL-edge-driven slave acks
// per a mask and records received bytes; a quarter-indexed waveform model
// gives the expected SCL/SDA per cycle.
module tb_i2c_write_master;

    localparam int CLK_DIV = 4;
    localparam int N_QTR   = 116;
    localparam int LAT     = N_QTR * CLK_DIV;

    logic        clk      = 1'b0;
    logic        reset    = 1'b1;
    logic        start    = 1'b0;
    logic [23:0] i2c_data = '0;
    logic        done;
    logic        ack;
    logic        i2c_sclk;
    wire         sda_line;

    int n_chk  = 0;
    int n_pass = 0;

    // slave state
    logic       s_pscl    = 1'b1;
    logic       s_psda    = 1'b1;
    logic       s_drive   = 1'b0;
    logic       s_in_ack  = 1'b0;
    logic       s_active  = 1'b0;
    logic [3:0] s_bits    = '0;
    logic [1:0] s_byte    = '0;
    logic [2:0] s_ackmask = 3'b111;
    logic [7:0] s_rx [3];

    always #5 clk = ~clk;

    pullup (sda_line);
    assign sda_line = s_drive ? 1'b0 : 1'bz;

    i2c_write_master #(
        .CLK_DIV (CLK_DIV)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .i2c_data (i2c_data),
        .start    (start),
        .done     (done),
        .ack      (ack),
        .i2c_sclk (i2c_sclk),
        .i2c_sdat (sda_line)
    );

    // Slave: detects START/STOP, shifts bits on SCL rise, drives ACK slot
    always @(posedge clk) begin
        s_pscl <= i2c_sclk;
        s_psda <= sda_line;
        if (reset) begin
            s_drive  <= 1'b0;
            s_in_ack <= 1'b0;
            s_active <= 1'b0;
        end else if (s_pscl && i2c_sclk && s_psda && !sda_line) begin
            s_active <= 1'b1;
            s_bits   <= '0;
            s_byte   <= '0;
            s_in_ack <= 1'b0;
            s_drive  <= 1'b0;
            for (int i = 0; i < 3; i++) s_rx[i] <= '0;
        end else if (s_pscl && i2c_sclk && !s_psda && sda_line) begin
            s_active <= 1'b0;
            s_drive  <= 1'b0;
        end else if (s_active) begin
            if (!s_pscl && i2c_sclk && !s_in_ack && s_bits < 4'd8) begin
                if (s_byte < 2'd3) s_rx[s_byte] <= {s_rx[s_byte][6:0], sda_line};
                s_bits <= s_bits + 4'd1;
            end else if (s_pscl && !i2c_sclk) begin
                if (s_in_ack) begin
                    s_drive  <= 1'b0;
                    s_in_ack <= 1'b0;
                    s_bits   <= '0;
                    s_byte   <= s_byte + 2'd1;
                end else if (s_bits == 4'd8) begin
                    s_in_ack <= 1'b1;
                    s_drive  <= (s_byte < 2'd3) ? s_ackmask[s_byte] : 1'b0;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic exp_scl(input int n);
        if (n < 4) return 1'b1;
        if (n < 112) return (((n - 4) % 4) >= 2) ? 1'b1 : 1'b0;
        return ((n - 112) >= 1) ? 1'b1 : 1'b0;
    endfunction

    function automatic logic exp_sda(input int n, input logic [23:0] d, input logic [2:0] am);
        int s, by, bi;
        logic [23:0] t;
        logic [2:0]  m;
        if (n < 4) return (n < 2) ? 1'b1 : 1'b0;
        if (n < 112) begin
            s  = (n - 4) / 4;
            by = s / 9;
            bi = s % 9;
            if (bi < 8) begin
                t = d << (by * 8 + bi);
                return t[23];
            end
            m = am >> by;
            return ~m[0];
        end
        return ((n - 112) >= 2) ? 1'b1 : 1'b0;
    endfunction

    // One transfer; poke_at re-pulses start with other data, rst_at aborts via reset
    task automatic run_xfer(input logic [23:0] data, input logic [2:0] am,
                            input int poke_at, input int rst_at, input string nm);
        int   falls = 0;
        int   rises = 0;
        logic pscl  = 1'b1;
        logic psda  = 1'b1;
        int   q;
        logic [7:0] eb;
        s_ackmask = am;
        i2c_data  = data;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int e = 0; e < LAT; e++) begin
            q = e / CLK_DIV;
            if (e == poke_at) begin
                start    = 1'b1;
                i2c_data = ~data;
            end else begin
                start = 1'b0;
            end
            if (e == rst_at) begin
                reset = 1'b1;
                #1;
                chk($sformatf("%s rst_scl", nm), 32'(i2c_sclk), 32'd1);
                chk($sformatf("%s rst_sda", nm), 32'(sda_line), 32'd1);
                chk($sformatf("%s rst_done", nm), 32'(done), 32'd0);
                chk($sformatf("%s rst_ack", nm), 32'(ack), 32'd0);
                repeat (2) @(negedge clk);
                reset = 1'b0;
                @(negedge clk);
                return;
            end
            chk($sformatf("%s scl q%0d e%0d", nm, q, e), 32'(i2c_sclk), 32'(exp_scl(q)));
            if (exp_scl(q))
                chk($sformatf("%s sda q%0d e%0d", nm, q, e), 32'(sda_line), 32'(exp_sda(q, data, am)));
            if (e == 0 || e == LAT - 1) begin
                chk($sformatf("%s done_low e%0d", nm, e), 32'(done), 32'd0);
                chk($sformatf("%s ack_low e%0d", nm, e), 32'(ack), 32'd0);
            end
            if (pscl && i2c_sclk && (psda != sda_line)) begin
                if (sda_line) rises++;
                else falls++;
            end
            pscl = i2c_sclk;
            psda = sda_line;
            @(negedge clk);
        end
        start = 1'b0;
        chk($sformatf("%s done", nm), 32'(done), 32'd1);
        chk($sformatf("%s ack", nm), 32'(ack), 32'(&am));
        chk($sformatf("%s sda_fall_scl_hi", nm), 32'(falls), 32'd1);
        chk($sformatf("%s sda_rise_scl_hi", nm), 32'(rises), 32'd1);
        for (int b = 0; b < 3; b++) begin
            eb = data[23 - 8 * b -: 8];
            chk($sformatf("%s rx_byte%0d", nm, b), 32'(s_rx[b]), 32'(eb));
        end
    endtask

    initial begin
        logic [23:0] d;
        logic [2:0]  m;

        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset scl", 32'(i2c_sclk), 32'd1);
        chk("reset sda", 32'(sda_line), 32'd1);
        chk("reset done", 32'(done), 32'd0);
        chk("reset ack", 32'(ack), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        run_xfer(24'h340C10, 3'b111, -1, -1, "basic");
        repeat (5) @(negedge clk);
        chk("idle hold done", 32'(done), 32'd1);
        chk("idle hold ack", 32'(ack), 32'd1);
        chk("idle scl", 32'(i2c_sclk), 32'd1);
        chk("idle sda", 32'(sda_line), 32'd1);

        run_xfer(24'($urandom), 3'b101, -1, -1, "nack_b1");
        repeat (3) @(negedge clk);
        chk("nack hold ack", 32'(ack), 32'd0);

        run_xfer(24'($urandom), 3'b111, 100, -1, "ignored_start");
        repeat (2) @(negedge clk);

        d = 24'($urandom);
        d[6] = 1'b0;
        run_xfer(d, 3'b111, -1, 81 * CLK_DIV + 1, "abort");
        run_xfer(24'($urandom), 3'b111, -1, -1, "after_rst");
        run_xfer(24'($urandom), 3'b111, -1, -1, "b2b");

        for (int k = 0; k < 4; k++) begin
            repeat ($urandom_range(1, 5)) @(negedge clk);
            d = 24'($urandom);
            m = 3'($urandom);
            run_xfer(d, m, -1, -1, $sformatf("rand%0d", k));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
